// File: rtl/soc_bus_arbiter.sv
// soc_bus_arbiter: two-master (fetch I, load/store D) to one-slave bus arbiter.
// Allows one outstanding transaction, uses round-robin arbitration on conflict,
// and returns an error response if the slave does not answer within TIMEOUT
// cycles of WAIT.
module soc_bus_arbiter #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst,
   // instruction-fetch master
   input  logic                i_valid,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic                i_ready,
   output logic                i_rvalid,
   output logic [DATA_W-1:0]   i_rdata,
   output logic                i_err,
   // load/store master
   input  logic                d_valid,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_wstrb,
   input  logic                d_we,
   output logic                d_ready,
   output logic                d_rvalid,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_err,
   // downstream slave port
   output logic                m_valid,
   output logic [ADDR_W-1:0]   m_addr,
   output logic [DATA_W-1:0]   m_wdata,
   output logic [DATA_W/8-1:0] m_wstrb,
   output logic                m_we,
   input  logic                m_ready,
   input  logic                m_rvalid,
   input  logic [DATA_W-1:0]   m_rdata
);

   localparam int unsigned STRB_W = DATA_W / 8;
   // The counter only has to hold 0..TIMEOUT-1: the error fires on the cycle
   // the count would have reached TIMEOUT.
   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT
   } state_t;

   typedef enum logic {
      OWN_I,
      OWN_D
   } owner_t;

   state_t              state_q, state_d;
   owner_t              last_q, last_d;
   owner_t              owner_q, owner_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [STRB_W-1:0]   wstrb_q, wstrb_d;
   logic                we_q, we_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                i_rvalid_q, i_rvalid_d;
   logic                i_err_q, i_err_d;
   logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
   logic                d_rvalid_q, d_rvalid_d;
   logic                d_err_q, d_err_d;
   logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
   logic                grant_i, grant_d;

   // Round-robin pick: on conflict the requester that did not win last time goes.
   always_comb begin
      grant_i = i_valid && (!d_valid || (last_q == OWN_D));
      grant_d = d_valid && !grant_i;
      i_ready = (state_q == S_IDLE) && grant_i;
      d_ready = (state_q == S_IDLE) && grant_d;
   end

   // Next-state, request latching, watchdog counting and response generation.
   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      owner_d    = owner_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      we_d       = we_q;
      cnt_d      = cnt_q;
      i_rvalid_d = 1'b0;
      i_err_d    = 1'b0;
      i_rdata_d  = i_rdata_q;
      d_rvalid_d = 1'b0;
      d_err_d    = 1'b0;
      d_rdata_d  = d_rdata_q;

      case (state_q)
         S_IDLE: begin
            if (i_ready) begin
               owner_d = OWN_I;
               last_d  = OWN_I;
               addr_d  = i_addr;
               wdata_d = '0;
               wstrb_d = '0;
               we_d    = 1'b0;
               state_d = S_ISSUE;
            end else if (d_ready) begin
               owner_d = OWN_D;
               last_d  = OWN_D;
               addr_d  = d_addr;
               wdata_d = d_wdata;
               wstrb_d = d_wstrb;
               we_d    = d_we;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (m_ready) begin
               state_d = S_WAIT;
               cnt_d   = '0;
            end
         end
         S_WAIT: begin
            // A real response takes priority over the watchdog in the same cycle.
            if (m_rvalid) begin
               state_d = S_IDLE;
               if (owner_q == OWN_I) begin
                  i_rvalid_d = 1'b1;
                  i_rdata_d  = m_rdata;
               end else begin
                  d_rvalid_d = 1'b1;
                  d_rdata_d  = m_rdata;
               end
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_IDLE;
               if (owner_q == OWN_I) begin
                  i_rvalid_d = 1'b1;
                  i_err_d    = 1'b1;
                  i_rdata_d  = '0;
               end else begin
                  d_rvalid_d = 1'b1;
                  d_err_d    = 1'b1;
                  d_rdata_d  = '0;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset drops any in-flight transaction.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         last_q     <= OWN_D;
         owner_q    <= OWN_I;
         addr_q     <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         we_q       <= 1'b0;
         cnt_q      <= '0;
         i_rvalid_q <= 1'b0;
         i_err_q    <= 1'b0;
         i_rdata_q  <= '0;
         d_rvalid_q <= 1'b0;
         d_err_q    <= 1'b0;
         d_rdata_q  <= '0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         owner_q    <= owner_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         we_q       <= we_d;
         cnt_q      <= cnt_d;
         i_rvalid_q <= i_rvalid_d;
         i_err_q    <= i_err_d;
         i_rdata_q  <= i_rdata_d;
         d_rvalid_q <= d_rvalid_d;
         d_err_q    <= d_err_d;
         d_rdata_q  <= d_rdata_d;
      end
   end

   // Downstream request is driven straight from the latched registers.
   always_comb begin
      m_valid  = (state_q == S_ISSUE);
      m_addr   = addr_q;
      m_wdata  = wdata_q;
      m_wstrb  = wstrb_q;
      m_we     = we_q;
      i_rvalid = i_rvalid_q;
      i_err    = i_err_q;
      i_rdata  = i_rdata_q;
      d_rvalid = d_rvalid_q;
      d_err    = d_err_q;
      d_rdata  = d_rdata_q;
   end

endmodule

// File: tb/tb_soc_bus_arbiter.sv
// Scoreboard testbench for soc_bus_arbiter: directed stimulus pushes expected
// downstream requests and responses; a monitor pops and compares them.
module tb_soc_bus_arbiter;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        we;
   } req_t;

   typedef struct {
      logic        is_d;
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } rsp_t;

   logic        clk;
   logic        rst;
   logic        i_valid;
   logic [31:0] i_addr;
   logic        i_ready;
   logic        i_rvalid;
   logic [31:0] i_rdata;
   logic        i_err;
   logic        d_valid;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_wstrb;
   logic        d_we;
   logic        d_ready;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        d_err;
   logic        m_valid;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [3:0]  m_wstrb;
   logic        m_we;
   logic        m_ready;
   logic        m_rvalid;
   logic [31:0] m_rdata;

   // slave model and stray-response injector
   logic        s_rvalid;
   logic [31:0] s_rdata;
   logic [31:0] s_addr;
   int          s_phase;
   int          s_cnt;
   int          sl_rdy_dly;
   int          sl_rsp_dly;
   bit          sl_drop;
   logic        inj_rvalid;
   logic [31:0] inj_rdata;

   req_t exp_req[$];
   rsp_t exp_rsp[$];
   int   n_cmp;
   int   n_bad;
   int   cyc;
   int   acc_i;
   int   acc_d;

   assign m_rvalid = s_rvalid | inj_rvalid;
   assign m_rdata  = inj_rvalid ? inj_rdata : s_rdata;

   soc_bus_arbiter #(
      .ADDR_W (32),
      .DATA_W (32),
      .TIMEOUT(8)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .i_valid (i_valid),
      .i_addr  (i_addr),
      .i_ready (i_ready),
      .i_rvalid(i_rvalid),
      .i_rdata (i_rdata),
      .i_err   (i_err),
      .d_valid (d_valid),
      .d_addr  (d_addr),
      .d_wdata (d_wdata),
      .d_wstrb (d_wstrb),
      .d_we    (d_we),
      .d_ready (d_ready),
      .d_rvalid(d_rvalid),
      .d_rdata (d_rdata),
      .d_err   (d_err),
      .m_valid (m_valid),
      .m_addr  (m_addr),
      .m_wdata (m_wdata),
      .m_wstrb (m_wstrb),
      .m_we    (m_we),
      .m_ready (m_ready),
      .m_rvalid(m_rvalid),
      .m_rdata (m_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic logic [31:0] resp_for(input logic [31:0] a);
      return (a == 32'h100) ? 32'h13 : a + 32'h1111_0000;
   endfunction

   function automatic void push_req(input logic [31:0] a, input logic [31:0] w,
                                    input logic [3:0] s, input logic we);
      req_t r;
      r.addr = a; r.wdata = w; r.wstrb = s; r.we = we;
      exp_req.push_back(r);
   endfunction

   function automatic void push_rsp(input logic is_d, input logic [31:0] rd,
                                    input logic err, input int lat);
      rsp_t r;
      r.is_d = is_d; r.rdata = rd; r.err = err; r.lat = lat;
      exp_rsp.push_back(r);
   endfunction

   // slave: accepts after sl_rdy_dly stalled cycles, answers sl_rsp_dly WAIT cycles later
   initial begin
      m_ready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_addr = '0;
      s_phase = 0; s_cnt = 0;
      forever begin
         @(posedge clk); #1;
         m_ready  = 1'b0;
         s_rvalid = 1'b0;
         if (rst) begin
            s_phase = 0; s_cnt = 0;
         end else if (s_phase == 0) begin
            if (m_valid) begin
               if (s_cnt == sl_rdy_dly) begin
                  m_ready = 1'b1; s_addr = m_addr; s_phase = 1; s_cnt = 0;
               end else begin
                  s_cnt++;
               end
            end
         end else begin
            if (sl_drop) begin
               s_phase = 0;
            end else if (s_cnt == sl_rsp_dly) begin
               s_rvalid = 1'b1; s_rdata = resp_for(s_addr); s_phase = 0; s_cnt = 0;
            end else begin
               s_cnt++;
            end
         end
      end
   end

   // monitor: compares downstream handshakes and master responses against the queues
   initial begin
      req_t        er;
      rsp_t        es;
      bit          p_stall;
      logic [31:0] p_addr, p_wdata;
      logic [3:0]  p_wstrb;
      logic        p_we;
      p_stall = 1'b0; p_addr = '0; p_wdata = '0; p_wstrb = '0; p_we = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            p_stall = 1'b0;
         end else begin
            if (m_valid && p_stall) begin
               chk("m_addr_stable", 64'(m_addr), 64'(p_addr));
               chk("m_wdata_stable", 64'(m_wdata), 64'(p_wdata));
               chk("m_wstrb_stable", 64'(m_wstrb), 64'(p_wstrb));
               chk("m_we_stable", 64'(m_we), 64'(p_we));
            end
            p_stall = m_valid && !m_ready;
            p_addr = m_addr; p_wdata = m_wdata; p_wstrb = m_wstrb; p_we = m_we;
            if (m_valid && m_ready) begin
               chk("req_expected", 64'(exp_req.size() > 0), 64'(1));
               if (exp_req.size() > 0) begin
                  er = exp_req.pop_front();
                  chk("m_addr", 64'(m_addr), 64'(er.addr));
                  chk("m_wdata", 64'(m_wdata), 64'(er.wdata));
                  chk("m_wstrb", 64'(m_wstrb), 64'(er.wstrb));
                  chk("m_we", 64'(m_we), 64'(er.we));
               end
            end
            if (i_rvalid || d_rvalid) begin
               chk("rsp_onehot", 64'(i_rvalid && d_rvalid), 64'(0));
               chk("rsp_expected", 64'(exp_rsp.size() > 0), 64'(1));
               if (exp_rsp.size() > 0) begin
                  es = exp_rsp.pop_front();
                  chk("rsp_port_is_d", 64'(d_rvalid), 64'(es.is_d));
                  chk("rsp_rdata", 64'(d_rvalid ? d_rdata : i_rdata), 64'(es.rdata));
                  chk("rsp_err", 64'(d_rvalid ? d_err : i_err), 64'(es.err));
                  if (es.lat >= 0)
                     chk("rsp_latency", 64'(cyc - (es.is_d ? acc_d : acc_i)), 64'(es.lat));
               end
            end
         end
      end
   end

   task automatic do_i(input logic [31:0] addr);
      bit got;
      got = 1'b0;
      i_valid = 1'b1; i_addr = addr;
      for (int k = 0; k < 300 && !got; k++) begin
         @(negedge clk);
         if (i_ready) begin got = 1'b1; acc_i = cyc; end
         @(posedge clk); #1;
      end
      i_valid = 1'b0; i_addr = '1;
      chk("i_accepted", 64'(got), 64'(1));
   endtask

   task automatic do_d(input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input logic we);
      bit got;
      got = 1'b0;
      d_valid = 1'b1; d_addr = addr; d_wdata = wdata; d_wstrb = wstrb; d_we = we;
      for (int k = 0; k < 300 && !got; k++) begin
         @(negedge clk);
         if (d_ready) begin got = 1'b1; acc_d = cyc; end
         @(posedge clk); #1;
      end
      d_valid = 1'b0; d_addr = '1; d_wdata = '1; d_wstrb = '1; d_we = 1'b1;
      chk("d_accepted", 64'(got), 64'(1));
   endtask

   task automatic drain();
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 200 && !ok; k++) begin
         @(posedge clk); #2;
         ok = (exp_req.size() == 0) && (exp_rsp.size() == 0);
      end
      chk("drain", 64'(ok), 64'(1));
      @(posedge clk); #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_i_ready"}, 64'(i_ready), 64'(0));
      chk({tag, "_i_rvalid"}, 64'(i_rvalid), 64'(0));
      chk({tag, "_i_rdata"}, 64'(i_rdata), 64'(0));
      chk({tag, "_i_err"}, 64'(i_err), 64'(0));
      chk({tag, "_d_ready"}, 64'(d_ready), 64'(0));
      chk({tag, "_d_rvalid"}, 64'(d_rvalid), 64'(0));
      chk({tag, "_d_rdata"}, 64'(d_rdata), 64'(0));
      chk({tag, "_d_err"}, 64'(d_err), 64'(0));
      chk({tag, "_m_valid"}, 64'(m_valid), 64'(0));
      chk({tag, "_m_addr"}, 64'(m_addr), 64'(0));
      chk({tag, "_m_wdata"}, 64'(m_wdata), 64'(0));
      chk({tag, "_m_wstrb"}, 64'(m_wstrb), 64'(0));
      chk({tag, "_m_we"}, 64'(m_we), 64'(0));
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1);
   end

   initial begin
      n_cmp = 0; n_bad = 0; acc_i = 0; acc_d = 0;
      rst = 1'b1;
      i_valid = 1'b0; i_addr = '0;
      d_valid = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0; d_we = 1'b0;
      sl_rdy_dly = 0; sl_rsp_dly = 0; sl_drop = 1'b0;
      inj_rvalid = 1'b0; inj_rdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // conflict after reset goes to I, then D; repeated to show alternation
      for (int r = 0; r < 2; r++) begin
         push_req(32'h0, 32'h0, 4'h0, 1'b0);
         push_req(32'h2000, 32'hDEAD_BEEF, 4'hF, 1'b0);
         push_rsp(1'b0, 32'h1111_0000, 1'b0, 3);
         push_rsp(1'b1, 32'h1111_2000, 1'b0, 3);
         fork
            do_i(32'h0);
            do_d(32'h2000, 32'hDEAD_BEEF, 4'hF, 1'b0);
         join
         chk("conflict_d_after_i", 64'(acc_d - acc_i), 64'(3));
         drain();
      end

      // single fetch, best-case latency
      push_req(32'h100, 32'h0, 4'h0, 1'b0);
      push_rsp(1'b0, 32'h13, 1'b0, 3);
      do_i(32'h100);
      drain();

      // store
      push_req(32'h1004, 32'hCAFE_BABE, 4'b0011, 1'b1);
      push_rsp(1'b1, 32'h1111_1004, 1'b0, 3);
      do_d(32'h1004, 32'hCAFE_BABE, 4'b0011, 1'b1);
      drain();

      // backpressure: slave stalls 5 cycles while a fetch waits behind the load
      sl_rdy_dly = 5;
      push_req(32'h2004, 32'h0, 4'h0, 1'b0);
      push_req(32'h104, 32'h0, 4'h0, 1'b0);
      push_rsp(1'b1, 32'h1111_2004, 1'b0, 8);
      push_rsp(1'b0, 32'h1111_0104, 1'b0, 8);
      fork
         do_d(32'h2004, 32'h0, 4'h0, 1'b0);
         begin
            @(posedge clk); #1;
            do_i(32'h104);
         end
         begin
            @(posedge clk); #1;
            repeat (6) begin
               @(negedge clk);
               chk("bp_i_ready_low", 64'(i_ready), 64'(0));
            end
         end
      join
      chk("bp_i_accept_after_d_rsp", 64'(acc_i - acc_d), 64'(8));
      drain();
      sl_rdy_dly = 0;

      // timeout: load never answered, then a late stray response is ignored
      sl_drop = 1'b1;
      push_req(32'h3000, 32'h0, 4'h0, 1'b0);
      push_rsp(1'b1, 32'h0, 1'b1, 10);
      do_d(32'h3000, 32'h0, 4'h0, 1'b0);
      for (int k = 0; k < 50 && cyc < acc_d + 12; k++) begin
         @(posedge clk); #1;
      end
      inj_rvalid = 1'b1; inj_rdata = 32'h7777_7777;
      @(posedge clk); #1;
      inj_rvalid = 1'b0;
      repeat (4) begin
         @(negedge clk);
         chk("stray_d_rvalid", 64'(d_rvalid), 64'(0));
         chk("stray_i_rvalid", 64'(i_rvalid), 64'(0));
      end
      sl_drop = 1'b0;
      drain();

      // response arriving in the last WAIT cycle beats the watchdog
      sl_rsp_dly = 7;
      push_req(32'h3004, 32'h0, 4'h0, 1'b0);
      push_rsp(1'b1, 32'h1111_3004, 1'b0, 10);
      do_d(32'h3004, 32'h0, 4'h0, 1'b0);
      drain();
      sl_rsp_dly = 0;

      // reset while waiting: no response, outputs cleared, last_grant back to D
      sl_drop = 1'b1;
      push_req(32'h80, 32'h0, 4'h0, 1'b0);
      do_i(32'h80);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk_all_zero("midrst");
      repeat (10) begin
         @(negedge clk);
         chk("midrst_no_i_rvalid", 64'(i_rvalid), 64'(0));
      end
      @(posedge clk); #1;
      sl_drop = 1'b0;
      push_req(32'h40, 32'h0, 4'h0, 1'b0);
      push_req(32'h44, 32'h5555_AAAA, 4'hC, 1'b0);
      push_rsp(1'b0, 32'h1111_0040, 1'b0, 3);
      push_rsp(1'b1, 32'h1111_0044, 1'b0, 3);
      fork
         do_i(32'h40);
         do_d(32'h44, 32'h5555_AAAA, 4'hC, 1'b0);
      join
      drain();

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/soc_bus_arbiter.md
Name: soc_bus_arbiter

Overview:
Two-master, single-slave bus arbiter for the SoC memory/peripheral bus. It shares one downstream port between the core's instruction-fetch port (I) and its load/store port (D). It allows one outstanding transaction at a time, uses round-robin arbitration on conflict, and has a response watchdog. It sits between the rv32i core and the RAM/UART address decoder inside the top-level SoC.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width; strobe width is DATA_W/8
TIMEOUT, 255, cycles spent in WAIT without m_rvalid before an error response is returned (must be >= 1)

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
i_valid  in  1  instruction-fetch request
i_addr  in  ADDR_W  fetch address
i_ready  out  1  fetch request accepted this cycle
i_rvalid  out  1  fetch response valid (one-cycle pulse)
i_rdata  out  DATA_W  fetch response data
i_err  out  1  fetch response is a timeout error; qualified by i_rvalid
d_valid  in  1  data request
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_wstrb  in  DATA_W/8  byte strobes
d_we  in  1  1 = store, 0 = load
d_ready  out  1  data request accepted this cycle
d_rvalid  out  1  data response or store ack (one-cycle pulse)
d_rdata  out  DATA_W  load data
d_err  out  1  data timeout error; qualified by d_rvalid
m_valid  out  1  downstream request valid
m_addr  out  ADDR_W  downstream address
m_wdata  out  DATA_W  downstream store data
m_wstrb  out  DATA_W/8  downstream strobes
m_we  out  1  downstream write enable
m_ready  in  1  downstream accepts request
m_rvalid  in  1  downstream response or write ack
m_rdata  in  DATA_W  downstream read data

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset values: state=IDLE, last_grant=D, timeout counter=0. All outputs are 0.
- IDLE state:
  - x_ready is combinational: asserted when state==IDLE, x_valid=1, and x wins arbitration.
  - If only one of i_valid/d_valid is high, that requester wins.
  - If both are high, the requester not equal to last_grant wins. After reset, the first conflict goes to I.
  - On acceptance: latch addr, wdata, wstrb, we, and owner into registers; update last_grant; go to ISSUE.
- Request field rules:
  - For I requests, m_we=0, m_wstrb=0, m_wdata=0.
  - Requesters hold valid and fields stable until x_ready. Fields are sampled only in the x_ready cycle.
- ISSUE state:
  - m_valid=1, with m_* driven from the latched registers and held stable until m_ready.
  - On m_valid && m_ready: go to WAIT, clear the counter.
  - ISSUE never times out; it stalls indefinitely.
- WAIT state:
  - m_valid=0.
  - m_rvalid is honoured only in WAIT, so the slave responds at least 1 cycle after acceptance.
  - On m_rvalid: next cycle the owner sees x_rvalid=1, x_rdata=m_rdata (registered), x_err=0. State returns to IDLE at the same edge.
  - Stores also wait for m_rvalid as the ack. For a store ack, x_rdata = m_rdata as driven.
  - Counter increments each WAIT cycle without m_rvalid. When it reaches TIMEOUT: next cycle owner x_rvalid=1, x_err=1, x_rdata=0; go to IDLE.
  - If m_rvalid arrives in the same cycle the counter reaches TIMEOUT, the real response wins.
- Responses:
  - x_rvalid/x_err are single-cycle pulses and are never asserted to the non-owner.
  - x_rdata holds its last value otherwise.
- Best-case latency: accept at cycle 0, m_valid+m_ready at cycle 1, m_rvalid at cycle 2, x_rvalid at cycle 3. The next acceptance can occur in cycle 3.
- Stray m_rvalid outside WAIT (including a late response after timeout) is ignored.
- Reset mid-operation: the in-flight transaction is dropped with no response. m_valid and all pulses are 0 in the cycle after rst is sampled. last_grant returns to D.

Test Plan:
- Single fetch: i_valid=1, i_addr=0x100; slave sets m_ready=1 on the first m_valid and m_rvalid=1, m_rdata=0x00000013 the next cycle -> i_ready at c0; m_valid/m_addr=0x100, m_we=0, m_wstrb=0 at c1; i_rvalid=1, i_rdata=0x13, i_err=0 at c3; d_rvalid stays 0.
- Conflict after reset: i_valid and d_valid held, i_addr=0x0, d_addr=0x2000 -> I served first, then D. Both re-asserted -> I, then D again (alternation). m_addr sequence 0x0, 0x2000, 0x0, 0x2000.
- Store: d_we=1, d_addr=0x1004, d_wdata=0xCAFEBABE, d_wstrb=4'b0011 -> m_* match exactly with m_we=1; d_rvalid=1, d_err=0 one cycle after ack.
- Backpressure: m_ready held 0 for 5 cycles with i_valid also pending -> m_valid and m_* stable all 5 cycles; i_ready=0 until the D response completes.
- Timeout: TIMEOUT=8, load never answered -> d_rvalid=1, d_err=1, d_rdata=0 after 8 WAIT cycles; an m_rvalid injected 2 cycles later produces no response.
- Reset in WAIT: rst pulsed 1 cycle while waiting -> no x_rvalid; all outputs 0. A subsequent fetch to 0x40 completes normally with 3-cycle latency.
